jtdsp16_cache: RTL and testbench

// Instruction cache and loop sequencer for the DSP16 do/redo instructions.
// - Consumes do_start/do_data from the instruction decoder.
// - Records the N words that follow a do while they are fetched from ROM, then replays them K-1 more times.
// - Feeds the decoder's instruction input through instr_dout and holds the XAAU PC during replays.
// - redo (N=0) replays the stored block K times without touching ROM.

---
 rtl/jtdsp16_cache.sv | 105 ++++++++++
 tb/tb_jtdsp16_cache.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/jtdsp16_cache.sv
// jtdsp16_cache: instruction cache and loop sequencer for DSP16 do/redo blocks
module jtdsp16_cache #(
    parameter int DW    = 16,
    parameter int DEPTH = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          do_start,
    input  logic [10:0]   do_data,
    input  logic          ins_adv,
    input  logic [DW-1:0] rom_dout,
    output logic [DW-1:0] instr_dout,
    output logic          cache_sel,
    output logic          pc_hold,
    output logic          busy,
    output logic          loop_end,
    output logic [3:0]    cache_n
);
    typedef enum logic [1:0] {IDLE, LOAD, REPLAY} state_t;

    state_t        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [3:0]    wr_ptr_q, rd_ptr_q, cache_n_q;
    logic [6:0]    iter_q;
    logic          cache_sel_q, pc_hold_q, loop_end_q;
    logic [3:0]    do_n;
    logic [6:0]    do_k;
    logic          last_wr, last_rd;

    assign do_n       = do_data[10:7];
    assign do_k       = do_data[6:0];
    assign last_wr    = wr_ptr_q == cache_n_q - 4'd1;
    assign last_rd    = rd_ptr_q == cache_n_q - 4'd1;
    assign instr_dout = cache_sel_q ? mem_q[rd_ptr_q] : rom_dout;
    assign cache_sel  = cache_sel_q;
    assign pc_hold    = pc_hold_q;
    assign busy       = state_q != IDLE;
    assign loop_end   = loop_end_q;
    assign cache_n    = cache_n_q;

    // Capture ROM words into the block store while loading; contents survive reset
    always_ff @(posedge clk) begin
        if (cen && ins_adv && state_q == LOAD) mem_q[wr_ptr_q] <= rom_dout;
    end

    // Loop sequencer: load the block once, then replay it until the iteration count runs out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= 4'd0;
            rd_ptr_q    <= 4'd0;
            cache_n_q   <= 4'd0;
            iter_q      <= 7'd0;
            cache_sel_q <= 1'b0;
            pc_hold_q   <= 1'b0;
            loop_end_q  <= 1'b0;
        end else if (cen) begin
            loop_end_q <= 1'b0;
            case (state_q)
                IDLE: if (do_start) begin
                    if (do_n != 4'd0) begin
                        cache_n_q <= do_n;
                        iter_q    <= (do_k == 7'd0) ? 7'd0 : do_k - 7'd1;
                        wr_ptr_q  <= 4'd0;
                        state_q   <= LOAD;
                    end else if (cache_n_q != 4'd0) begin
                        iter_q      <= (do_k == 7'd0) ? 7'd1 : do_k;
                        rd_ptr_q    <= 4'd0;
                        state_q     <= REPLAY;
                        cache_sel_q <= 1'b1;
                        pc_hold_q   <= 1'b1;
                    end
                end
                LOAD: if (ins_adv) begin
                    wr_ptr_q <= wr_ptr_q + 4'd1;
                    if (last_wr) begin
                        if (iter_q == 7'd0) begin
                            state_q    <= IDLE;
                            loop_end_q <= 1'b1;
                        end else begin
                            rd_ptr_q    <= 4'd0;
                            state_q     <= REPLAY;
                            cache_sel_q <= 1'b1;
                            pc_hold_q   <= 1'b1;
                        end
                    end
                end
                REPLAY: if (ins_adv) begin
                    rd_ptr_q <= last_rd ? 4'd0 : rd_ptr_q + 4'd1;
                    if (last_rd) begin
                        iter_q <= iter_q - 7'd1;
                        if (iter_q == 7'd1) begin
                            state_q     <= IDLE;
                            loop_end_q  <= 1'b1;
                            cache_sel_q <= 1'b0;
                            pc_hold_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtdsp16_cache.sv
// tb_jtdsp16_cache: directed bench with an expected instruction-stream model
module tb_jtdsp16_cache;
    logic        clk = 0, rst = 1, cen = 1, do_start = 0, ins_adv = 0;
    logic [10:0] do_data = '0;
    logic [15:0] rom_dout, instr_dout;
    logic        cache_sel, pc_hold, busy, loop_end;
    logic [3:0]  cache_n;
    int          checks = 0, errors = 0;
    int          pc = 0;
    logic        stall_chk = 0;

    typedef struct {
        logic [15:0] w;
        logic        s;
        logic        le;
    } ent_t;
    ent_t        exp_q[$];
    logic [15:0] mcache[15];
    int          model_n = 0, model_pc = 0;

    jtdsp16_cache dut (
        .clk(clk), .rst(rst), .cen(cen), .do_start(do_start), .do_data(do_data),
        .ins_adv(ins_adv), .rom_dout(rom_dout), .instr_dout(instr_dout),
        .cache_sel(cache_sel), .pc_hold(pc_hold), .busy(busy),
        .loop_end(loop_end), .cache_n(cache_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romw(input int a);
        return 16'(32'hA000 + a);
    endfunction

    assign rom_dout = romw(pc);

    always @(posedge clk) if (!rst && cen && ins_adv && !pc_hold) pc <= pc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && ((cen && ins_adv) || stall_chk)) begin
                chk("instr_dout", 32'(instr_dout), 32'(exp_q[0].w));
                chk("cache_sel", 32'(cache_sel), 32'(exp_q[0].s));
                chk("pc_hold", 32'(pc_hold), 32'(exp_q[0].s));
                if (cen && ins_adv) begin
                    chk("loop_end", 32'(loop_end), 32'(exp_q[0].le));
                    void'(exp_q.pop_front());
                end
            end else if (cen) chk("loop_end_idle", 32'(loop_end), 32'd0);
        end
    end

    task automatic push_rom(input int cnt, input logic le);
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back('{romw(model_pc), 1'b0, (i == 0) ? le : 1'b0});
            model_pc++;
        end
    endtask

    task automatic push_cache(input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < model_n; i++) exp_q.push_back('{mcache[i], 1'b1, 1'b0});
    endtask

    task automatic push_do(input int n, input int k);
        for (int i = 0; i < n; i++) begin
            mcache[i] = romw(model_pc);
            exp_q.push_back('{romw(model_pc), 1'b0, 1'b0});
            model_pc++;
        end
        model_n = n;
        push_cache((k == 0 ? 1 : k) - 1);
        push_rom(1, 1'b1);
    endtask

    task automatic push_redo(input int k);
        if (model_n != 0) begin
            push_cache(k == 0 ? 1 : k);
            push_rom(1, 1'b1);
        end
    endtask

    task automatic issue(input logic [3:0] n, input logic [6:0] k);
        ins_adv  = 0;
        do_start = 1;
        do_data  = {n, k};
        @(posedge clk);
        #1 do_start = 0;
    endtask

    task automatic run_n(input int n);
        ins_adv = 1;
        repeat (n) @(posedge clk);
        #1 ins_adv = 0;
    endtask

    task automatic drain();
        ins_adv = 1;
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
        #1 ins_adv = 0;
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cache_n", 32'(cache_n), 32'd0);
        chk("rst_cache_sel", 32'(cache_sel), 32'd0);
        chk("rst_loop_end", 32'(loop_end), 32'd0);
        rst = 0;
        // redo with an empty cache is ignored; ROM words 0,1 pass through
        issue(4'd0, 7'd5);
        chk("redo_empty_busy", 32'(busy), 32'd0);
        push_rom(2, 1'b0);
        drain();
        // do N=3,K=2: load A002..A004, replay once, then A005 from ROM
        issue(4'd3, 7'd2);
        chk("do_busy", 32'(busy), 32'd1);
        push_do(3, 2);
        drain();
        chk("do_cache_n", 32'(cache_n), 32'd3);
        chk("do_done_busy", 32'(busy), 32'd0);
        // redo K=3: nine cached words, ROM word A006 afterwards
        issue(4'd0, 7'd3);
        chk("redo_busy", 32'(busy), 32'd1);
        push_redo(3);
        drain();
        // redo K=2 with a stall in the middle of the second pass
        issue(4'd0, 7'd2);
        push_redo(2);
        run_n(4);
        stall_chk = 1;
        repeat (4) @(posedge clk);
        #1 chk("stall_word", 32'(instr_dout), 32'h0000A003);
        cen = 0;
        ins_adv = 1;
        repeat (2) @(posedge clk);
        #1 chk("cen_stall_word", 32'(instr_dout), 32'h0000A003);
        cen = 1;
        ins_adv = 0;
        stall_chk = 0;
        drain();
        chk("redo_cache_n", 32'(cache_n), 32'd3);
        // do N=2,K=1: plain load, no replay
        issue(4'd2, 7'd1);
        push_do(2, 1);
        drain();
        chk("do2_cache_n", 32'(cache_n), 32'd2);
        // reset in the middle of a replay
        issue(4'd0, 7'd3);
        push_redo(3);
        run_n(2);
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk("arst_cache_sel", 32'(cache_sel), 32'd0);
        chk("arst_pc_hold", 32'(pc_hold), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_loop_end", 32'(loop_end), 32'd0);
        chk("arst_cache_n", 32'(cache_n), 32'd0);
        exp_q.delete();
        model_n = 0;
        @(posedge clk);
        #1 rst = 0;
        model_pc = pc;
        issue(4'd0, 7'd5);
        chk("post_rst_redo_busy", 32'(busy), 32'd0);
        chk("post_rst_cache_sel", 32'(cache_sel), 32'd0);
        push_rom(3, 1'b0);
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
